dm_mmio: RTL and testbench
==========================

# dm_mmio

Data-side memory responder for the single-cycle CPU. It answers the core's data port (`MemWrite`, address, write data) and returns `readdata` in the same cycle. It combines a word-addressed data RAM with a small memory-mapped I/O region: an LED output register, a synchronized switch input, and a down-counting timer with an interrupt flag. It sits beside instruction memory at the top level, wired directly to the core's `aluout`, `writedata`, `MemWrite` and `readdata`.

## Interface
- `DM_AW`, 10 — RAM word-address width; RAM holds 2^DM_AW 32-bit words.
- `IO_W`, 16 — width of the LED and switch ports.
- `clk` in 1 — clock; all state updates on its rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `MemWrite` in 1 — write strobe from the core; sampled at the rising edge of `clk`.
- `addr` in 32 — byte address (core `aluout`); `addr[1:0]` is ignored.
- `writedata` in 32 — store data.
- `readdata` out 32 — load data; combinational from `addr`.
- `sw` in IO_W — asynchronous board switches.
- `led` out IO_W — LED register.
- `irq` out 1 — timer interrupt flag (level).

## Operation
- Address map (word aligned):
  - 0x0000_0000 to 0x0000_0000+4·2^DM_AW−4: RAM; index is `addr[DM_AW+1:2]`.
  - 0x0000_7F00 LED: read/write; only the low IO_W bits are stored; reads zero-extend.
  - 0x0000_7F04 SW: read-only; zero-extended synchronized switches.
  - 0x0000_7F10 TCTRL:
    - bit0 EN, read/write.
    - bit1 RELOAD, read/write.
    - bit2 FLAG: write 1 clears it, write 0 has no effect.
    - Other bits read as 0.
  - 0x0000_7F14 TLOAD: read/write. A write loads both TLOAD and TCOUNT.
  - 0x0000_7F18 TCOUNT: read-only.
- Unmapped addresses read 0. Writes to unmapped or read-only addresses are ignored.
- RAM: synchronous write when `MemWrite`; asynchronous read. RAM contents are not reset.
- Timer, evaluated each cycle with EN=1:
  - TCOUNT≠0: TCOUNT decrements by 1.
  - TCOUNT==0 (expiry): FLAG is set.
    - RELOAD=1: TCOUNT←TLOAD.
    - RELOAD=0: EN←0 and TCOUNT stays 0.
- With EN=0, TCOUNT holds.
- `irq` = FLAG.
- Simultaneous events:
  - Expiry and a FLAG clear in the same cycle: the set wins.
  - A TLOAD write and a decrement in the same cycle: the write wins.
  - A TCTRL write with EN=0 and an expiry in the same cycle: the write wins for EN; FLAG is still set.
- Switch input: a 2-flop synchronizer on `sw`. The SW register reflects `sw` 2 cycles after it changes.

## Timing
- Reset values: `led`=0, `irq`=0, TCTRL=0, TLOAD=0, TCOUNT=0, synchronizer flops=0.
- `readdata` is combinational. After reset, `readdata` is 0 for every I/O address.
- Read latency is 0 cycles, as the single-cycle core requires. A store is visible to a read in the cycle after its rising edge.
- Timer with EN written 1 and TCOUNT=N at edge k: TCOUNT=0 after edge k+N; FLAG=1 after edge k+N+1.
- Auto-reload period is TLOAD+1 cycles.
- Reset asserted mid-count clears all timer state immediately; RAM is unaffected.

## Structure
- Package `dm_mmio_pkg` holds:
  - Address constants: `ADDR_LED`, `ADDR_SW`, `ADDR_TCTRL`, `ADDR_TLOAD`, `ADDR_TCOUNT`.
  - TCTRL bit indices: `TC_EN`, `TC_RELOAD`, `TC_FLAG`.
- Sub-module `mmio_timer` holds EN, RELOAD, FLAG, TLOAD and TCOUNT.
  - Inputs: decoded write strobes and `writedata`.
  - Outputs: register values.
- The top level holds the RAM, the LED register, the synchronizer, address decode and the read mux.

## Test plan
- RAM: store 0xDEADBEEF to 0x0000_0010, then store 0x12345678 to 0x0000_0014 → loads from 0x10 and 0x14 return those values; a load from 0x0000_0013 returns 0xDEADBEEF.
- LED/SW:
  - Store 0xFFFF_A5A5 to 0x7F00 → `led`=0xA5A5 and a read of 0x7F00 returns 0x0000_A5A5.
  - Set `sw`=0x00F0 → a read of 0x7F04 returns 0x000000F0 from the 2nd edge on.
  - A store to 0x7F04 has no effect.
- One-shot timer: store 3 to 0x7F14, then 1 to 0x7F10 → TCOUNT reads 2, 1, 0; `irq` rises one cycle after 0 is reached; TCTRL reads 0x4.
- Auto-reload: TLOAD=2, TCTRL=0x3 → `irq` rises, then the timer keeps counting 2, 1, 0, 2, 1, 0.
- Simultaneous events: with RELOAD=1, store 0x4 to TCTRL on the expiry cycle → FLAG remains 1; a store of 0x7 on a later non-expiry cycle clears FLAG.
- Reset: assert `rst` mid-count (asynchronously, between edges) → `irq`=0, `led`=0, TCOUNT=0 immediately, and RAM data written earlier is still readable.

Source files
------------

// File: rtl/dm_mmio_pkg.sv
// dm_mmio_pkg: shared constants for the data-side memory responder.
//   ADDR_*      byte addresses of the memory-mapped I/O registers
//   TC_*        bit positions inside the timer control register (TCTRL)
//   word_hit()  word-granular address compare (byte offset ignored)
package dm_mmio_pkg;

   localparam logic [31:0] ADDR_LED    = 32'h0000_7F00;
   localparam logic [31:0] ADDR_SW     = 32'h0000_7F04;
   localparam logic [31:0] ADDR_TCTRL  = 32'h0000_7F10;
   localparam logic [31:0] ADDR_TLOAD  = 32'h0000_7F14;
   localparam logic [31:0] ADDR_TCOUNT = 32'h0000_7F18;

   localparam int TC_EN     = 0;
   localparam int TC_RELOAD = 1;
   localparam int TC_FLAG   = 2;

   function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] base);
      return (addr & ~32'h3) == (base & ~32'h3);
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: down-counting timer with one-shot / auto-reload modes.
//   clk, rst         clock, asynchronous active-high reset
//   we_tctrl         write strobe for TCTRL (EN, RELOAD, FLAG-clear)
//   we_tload         write strobe for TLOAD (also loads TCOUNT)
//   writedata        store data from the core
//   en, reload, flag TCTRL register bits
//   tload, tcount    reload value and current count
module mmio_timer
   import dm_mmio_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_tctrl,
   input  logic        we_tload,
   input  logic [31:0] writedata,
   output logic        en,
   output logic        reload,
   output logic        flag,
   output logic [31:0] tload,
   output logic [31:0] tcount
);

   logic expire;
   assign expire = en && (tcount == '0);

   // Later assignments in this block take priority: register writes override
   // the counting behaviour, while an expiry always sets FLAG.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en     <= 1'b0;
         reload <= 1'b0;
         flag   <= 1'b0;
         tload  <= '0;
         tcount <= '0;
      end else begin
         if (en) begin
            if (!expire)
               tcount <= tcount - 32'd1;
            else if (reload)
               tcount <= tload;
            else
               en <= 1'b0;
         end
         if (we_tload) begin
            tload  <= writedata;
            tcount <= writedata;
         end
         if (we_tctrl) begin
            en     <= writedata[TC_EN];
            reload <= writedata[TC_RELOAD];
         end
         if (expire)
            flag <= 1'b1;
         else if (we_tctrl && writedata[TC_FLAG])
            flag <= 1'b0;
      end
   end

endmodule

// File: rtl/dm_mmio.sv
// dm_mmio: data RAM plus memory-mapped I/O for the single-cycle core.
//   clk, rst   clock, asynchronous active-high reset
//   MemWrite   store strobe from the core
//   addr       byte address (core aluout); low two bits ignored
//   writedata  store data
//   readdata   combinational load data
//   sw         asynchronous board switches (synchronized internally)
//   led        LED register
//   irq        timer interrupt flag (level)
module dm_mmio
   import dm_mmio_pkg::*;
#(
   parameter int DM_AW = 10,
   parameter int IO_W  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            MemWrite,
   input  logic [31:0]     addr,
   input  logic [31:0]     writedata,
   output logic [31:0]     readdata,
   input  logic [IO_W-1:0] sw,
   output logic [IO_W-1:0] led,
   output logic            irq
);

   logic [31:0]      mem [0:(2**DM_AW)-1];
   logic [DM_AW-1:0] ram_idx;
   logic             ram_sel;
   logic             hit_led, hit_sw, hit_tctrl, hit_tload, hit_tcount;
   logic [IO_W-1:0]  sw_p0, sw_p1;
   logic             t_en, t_reload, t_flag;
   logic [31:0]      t_load, t_count;

   // Byte offset within a word carries no meaning for this port.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   assign ram_sel    = (addr[31:DM_AW+2] == '0);
   assign ram_idx    = addr[DM_AW+1:2];
   assign hit_led    = word_hit(addr, ADDR_LED);
   assign hit_sw     = word_hit(addr, ADDR_SW);
   assign hit_tctrl  = word_hit(addr, ADDR_TCTRL);
   assign hit_tload  = word_hit(addr, ADDR_TLOAD);
   assign hit_tcount = word_hit(addr, ADDR_TCOUNT);

   // RAM contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (MemWrite && ram_sel)
         mem[ram_idx] <= writedata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         led <= '0;
      else if (MemWrite && hit_led)
         led <= writedata[IO_W-1:0];
   end

   // Two-flop synchronizer for the asynchronous switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_p0 <= '0;
         sw_p1 <= '0;
      end else begin
         sw_p0 <= sw;
         sw_p1 <= sw_p0;
      end
   end

   mmio_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .we_tctrl  (MemWrite && hit_tctrl),
      .we_tload  (MemWrite && hit_tload),
      .writedata (writedata),
      .en        (t_en),
      .reload    (t_reload),
      .flag      (t_flag),
      .tload     (t_load),
      .tcount    (t_count)
   );

   assign irq = t_flag;

   always_comb begin
      readdata = '0;
      if (ram_sel)
         readdata = mem[ram_idx];
      else if (hit_led)
         readdata[IO_W-1:0] = led;
      else if (hit_sw)
         readdata[IO_W-1:0] = sw_p1;
      else if (hit_tctrl) begin
         readdata[TC_EN]     = t_en;
         readdata[TC_RELOAD] = t_reload;
         readdata[TC_FLAG]   = t_flag;
      end else if (hit_tload)
         readdata = t_load;
      else if (hit_tcount)
         readdata = t_count;
   end

endmodule

// File: tb/tb_dm_mmio.sv
module tb_dm_mmio;

   logic        clk, rst, MemWrite, irq;
   logic [31:0] addr, writedata, readdata;
   logic [15:0] sw, led;

   int checks = 0;
   int errors = 0;

   dm_mmio #(.DM_AW(10), .IO_W(16)) dut (
      .clk(clk), .rst(rst), .MemWrite(MemWrite), .addr(addr),
      .writedata(writedata), .readdata(readdata), .sw(sw), .led(led), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;   // store data, or expected load data
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemWrite  = 1'b1;
      addr      = a;
      writedata = d;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   task automatic check_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      MemWrite = 1'b0;
      addr     = a;
      #1;
      check(name, readdata, exp);
   endtask

   initial begin
      int exp_cnt [6];
      int exp_irq [6];

      rst = 1'b1; MemWrite = 1'b0; addr = '0; writedata = '0; sw = '0;
      check("reset led", {16'h0, led}, 32'h0);
      check("reset irq", {31'h0, irq}, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      step();

      // Reset-state reads, RAM, LED, read-only and unmapped accesses
      vecs.push_back('{1'b0, 32'h0000_7F00, 32'h0});
      vecs.push_back('{1'b0, 32'h0000_7F04, 32'h0});
      vecs.push_back('{1'b0, 32'h0000_7F10, 32'h0});
      vecs.push_back('{1'b0, 32'h0000_7F14, 32'h0});
      vecs.push_back('{1'b0, 32'h0000_7F18, 32'h0});
      vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 32'h0000_0014, 32'h12345678});
      vecs.push_back('{1'b0, 32'h0000_0010, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 32'h0000_0014, 32'h12345678});
      vecs.push_back('{1'b0, 32'h0000_0013, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 32'h0000_7F00, 32'hFFFF_A5A5});
      vecs.push_back('{1'b0, 32'h0000_7F00, 32'h0000_A5A5});
      vecs.push_back('{1'b1, 32'h0000_7F04, 32'h1234_5678});
      vecs.push_back('{1'b0, 32'h0000_7F04, 32'h0});
      vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111});
      vecs.push_back('{1'b1, 32'h0000_1000, 32'hAAAA_5555});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h1111_1111});
      vecs.push_back('{1'b0, 32'h0000_1000, 32'h0});
      vecs.push_back('{1'b0, 32'h0000_7F08, 32'h0});
      vecs.push_back('{1'b1, 32'h0000_7F18, 32'h0000_0009});
      vecs.push_back('{1'b0, 32'h0000_7F18, 32'h0});

      foreach (vecs[i]) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].data);
         else
            check_rd($sformatf("vec%0d rd %h", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
      end
      check("led port", {16'h0, led}, 32'h0000_A5A5);

      // Switch synchronizer latency
      step();
      sw = 16'h00F0;
      step();
      check_rd("sw after 1 edge", 32'h7F04, 32'h0);
      step();
      check_rd("sw after 2 edges", 32'h7F04, 32'h0000_00F0);

      // One-shot timer
      do_write(32'h7F14, 32'd3);
      do_write(32'h7F10, 32'h1);
      check_rd("oneshot start", 32'h7F18, 32'd3);
      for (int v = 2; v >= 0; v--) begin
         step();
         check_rd($sformatf("oneshot cnt %0d", v), 32'h7F18, v);
         check($sformatf("oneshot irq at %0d", v), {31'h0, irq}, 32'h0);
      end
      step();
      check("oneshot irq set", {31'h0, irq}, 32'h1);
      check_rd("oneshot tctrl", 32'h7F10, 32'h4);
      check_rd("oneshot cnt held", 32'h7F18, 32'h0);
      do_write(32'h7F10, 32'h4);
      check("flag cleared", {31'h0, irq}, 32'h0);
      check_rd("tctrl after clear", 32'h7F10, 32'h0);

      // Auto-reload
      do_write(32'h7F14, 32'd2);
      do_write(32'h7F10, 32'h3);
      check_rd("reload start", 32'h7F18, 32'd2);
      exp_cnt = '{1, 0, 2, 1, 0, 2};
      exp_irq = '{0, 0, 1, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
         step();
         check_rd($sformatf("reload cnt step%0d", i), 32'h7F18, exp_cnt[i]);
         check($sformatf("reload irq step%0d", i), {31'h0, irq}, exp_irq[i]);
      end

      // Clear attempt on the expiry edge: set wins, EN write wins
      step();
      step();
      check_rd("pre-expiry cnt", 32'h7F18, 32'd0);
      do_write(32'h7F10, 32'h4);
      check("expiry vs clear irq", {31'h0, irq}, 32'h1);
      check_rd("expiry vs clear tctrl", 32'h7F10, 32'h4);
      check_rd("expiry vs clear cnt", 32'h7F18, 32'd2);
      do_write(32'h7F10, 32'h7);
      check("non-expiry clear irq", {31'h0, irq}, 32'h0);
      check_rd("non-expiry tctrl", 32'h7F10, 32'h3);

      // TLOAD write beats decrement
      do_write(32'h7F14, 32'd5);
      check_rd("tload vs dec cnt", 32'h7F18, 32'd5);
      check_rd("tload vs dec load", 32'h7F14, 32'd5);
      step();
      check_rd("count after tload", 32'h7F18, 32'd4);
      repeat (5) step();
      check("irq before reset", {31'h0, irq}, 32'h1);
      check_rd("reloaded before reset", 32'h7F18, 32'd5);
      step();

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      check("rst irq", {31'h0, irq}, 32'h0);
      check("rst led", {16'h0, led}, 32'h0);
      check_rd("rst tcount", 32'h7F18, 32'h0);
      check_rd("rst tctrl", 32'h7F10, 32'h0);
      check_rd("rst tload", 32'h7F14, 32'h0);
      check_rd("rst sw", 32'h7F04, 32'h0);
      check_rd("rst ram 0x10", 32'h10, 32'hDEADBEEF);
      check_rd("rst ram 0x14", 32'h14, 32'h12345678);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_rd("post-rst tcount", 32'h7F18, 32'h0);
      check("post-rst irq", {31'h0, irq}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
